delay_line_server: RTL and testbench
====================================

Name: delay_line_server

Overview:
- Responder side of the DSP core's delay request interface: services `delay_read_req` / `delay_write_req` from the core.
- Holds `n_delays` independent circular sample buffers in one shared synchronous RAM.
- A write pushes one sample into the buffer selected by the handle.
- A read returns the sample written `arg` writes ago on that handle.
- Sits beside the DSP core; its outputs wire directly to the core's `delay_req_data_in`, `delay_read_ready` and `delay_write_ready`.

Parameters:
- `data_width`, 16, sample and handle/arg width.
- `n_delays`, 8, number of delay lines (handles 0..n_delays-1).
- `buf_len`, 1024, samples per line; must be a power of two.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `delay_read_req`  in  1  level request: read tap.
- `delay_write_req`  in  1  level request: push sample.
- `delay_req_handle`  in  data_width (signed)  delay line index.
- `delay_req_arg`  in  data_width (signed)  read: delay in samples; write: sample value.
- `delay_read_data`  out  data_width (signed)  read result; connects to the core's `delay_req_data_in`.
- `delay_read_ready`  out  1  one-cycle pulse, read data valid.
- `delay_write_ready`  out  1  one-cycle pulse, write committed.

Behaviour:
- RAM: `n_delays*buf_len` words, single port, one-cycle registered read. Address = `{handle[clog2(n_delays)-1:0], offset[clog2(buf_len)-1:0]}`.
- Per-line write pointer `wptr[h]`, width `clog2(buf_len)`.
- Reset (`reset`==0 at a clk edge):
  - state IDLE, all `wptr` 0, `delay_read_data` 0, both ready outputs 0.
  - RAM contents are not cleared.
  - Reset mid-operation aborts the request with no ready pulse; a write not yet committed is dropped.
- States: IDLE, RD_ADDR, RD_DATA, WR, RELEASE.
- IDLE:
  - `delay_read_req`=1: latch handle/arg, go to RD_ADDR.
  - Else `delay_write_req`=1: latch, go to WR.
  - Read has priority when both are high. The write request stays pending and is serviced after the read's RELEASE.
- Handle validity: valid iff 0 <= handle < `n_delays`.
- Read argument:
  - d = arg, clamped to [0, buf_len-1]; a negative arg gives d=0.
  - Address offset = (`wptr[h]` - 1 - d) mod buf_len, with natural wrap in pointer width.
  - d=0 returns the most recent write.
- RD_ADDR: drive the RAM address, go to RD_DATA.
- RD_DATA:
  - Register the RAM output into `delay_read_data`; pulse `delay_read_ready` for one cycle.
  - Invalid handle: `delay_read_data`=0 and a ready pulse is still issued.
  - Go to RELEASE.
- WR:
  - Valid handle: write arg at offset `wptr[h]`, then `wptr[h]` <= `wptr[h]`+1 (wraps buf_len-1 -> 0).
  - Invalid handle: no RAM or pointer change.
  - Either way, pulse `delay_write_ready` and go to RELEASE.
- RELEASE:
  - Wait until the serviced request line is low, then return to IDLE.
  - This prevents double-service of a held level request.
  - The other request line is ignored while in RELEASE.
- Latency, counting the IDLE accept edge as cycle 0:
  - read ready is high in cycle 3;
  - write ready is high in cycle 2;
  - the earliest next accept is one cycle after the request drops.
- `delay_read_data` holds its value until the next read completes.
- Unwritten RAM locations read back undefined unless DELAY_CLEAR_EN is defined.
- Only the low `clog2(n_delays)` handle bits and the clamped arg are used after the validity checks.

Optional Feature:
- Macro: DELAY_CLEAR_EN.
- When defined:
  - Adds input `clear` (1) and output `busy` (1).
  - `clear`=1 in IDLE, or the release of reset, starts a sweep: one RAM word per cycle is written with 0, `n_delays*buf_len` cycles, and all `wptr` are zeroed.
  - `busy`=1 during the sweep; requests are held off (not accepted, no ready) until the sweep ends.
  - `busy` resets to 1 and falls after the sweep.
  - A `clear` that arrives while a request is in progress is serviced on the next IDLE.
- When undefined: no `clear`/`busy` ports, no sweep, RAM starts undefined.

Test Plan:
- Reset, then write handle 2 with arg 0x1234; then read handle 2, arg 0 -> `delay_write_ready` in cycle 2, `delay_read_ready` in cycle 3, `delay_read_data`=0x1234.
- Write 5 samples 1..5 on handle 0, then read args 0, 4, 2 -> returns 5, 1, 3.
- Write buf_len+3 samples (values = index) on handle 1, read arg 0 -> 1026 (buf_len=1024); read arg 1023 -> 3; read arg 2000 (clamped) -> 3; read arg -7 -> 1026.
- Assert read and write simultaneously on handle 3 (prior last write 0x0055) -> read returns 0x0055 first, write acked only after read_req drops, next read arg 0 returns the new value.
- Handle 9 with n_delays=8: write then read -> both ready pulses issued, read data 0, no pointer of lines 0..7 changes.
- Hold `delay_write_req` high 10 cycles -> exactly one write and one `delay_write_ready` pulse. Separately, assert reset low in RD_DATA-1 -> no ready pulse, all pointers 0.

Source files
------------

// File: rtl/delay_line_server.sv
// Delay-line responder: n_delays circular sample buffers in one shared single-port RAM,
// serviced through level read/write requests. Optional RAM clear sweep under DELAY_CLEAR_EN.
module delay_line_server #(
    parameter int data_width = 16,
    parameter int n_delays   = 8,
    parameter int buf_len    = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
`ifdef DELAY_CLEAR_EN
    input  logic                         clear,
    output logic                         busy,
`endif
    input  logic                         delay_read_req,
    input  logic                         delay_write_req,
    input  logic signed [data_width-1:0] delay_req_handle,
    input  logic signed [data_width-1:0] delay_req_arg,
    output logic signed [data_width-1:0] delay_read_data,
    output logic                         delay_read_ready,
    output logic                         delay_write_ready
);

    localparam int hw    = (n_delays > 1) ? $clog2(n_delays) : 1;
    localparam int ow    = (buf_len > 1) ? $clog2(buf_len) : 1;
    localparam int aw    = hw + ow;
    localparam int depth = n_delays * buf_len;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        RELEASE
`ifdef DELAY_CLEAR_EN
        , SWEEP
`endif
    } state_t;

    state_t state, next_state;

    logic signed [data_width-1:0] lat_handle;
    logic signed [data_width-1:0] lat_arg;
    logic                         lat_is_read;
    logic [ow-1:0]                wptr [n_delays];

    logic signed [data_width-1:0] mem [depth];
    logic signed [data_width-1:0] ram_q;
    logic                         ram_we;
    logic [aw-1:0]                ram_addr;
    logic signed [data_width-1:0] ram_wdata;

    logic          handle_valid;
    logic [hw-1:0] line;
    logic [ow-1:0] d;
    logic [ow-1:0] rd_offset;
    logic          accept;
    logic          clear_go;

`ifdef DELAY_CLEAR_EN
    logic [aw-1:0] sweep_addr;
    logic          clear_pending;

    assign clear_go = clear || clear_pending;
    assign busy     = (state == SWEEP);
`else
    assign clear_go = 1'b0;
`endif

    assign handle_valid = (int'(lat_handle) >= 0) && (int'(lat_handle) < n_delays);
    assign line         = lat_handle[hw-1:0];
    assign accept       = (state == IDLE) && !clear_go && (delay_read_req || delay_write_req);

    // Negative delays mean "most recent"; delays beyond the buffer saturate at the oldest sample.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        d = '0;
        if (int'(lat_arg) > buf_len - 1)
            d = ow'(buf_len - 1);
        else if (int'(lat_arg) > 0)
            d = ow'(lat_arg);
    end

    assign rd_offset = wptr[line] - ow'(1) - d;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
`ifdef DELAY_CLEAR_EN
            state <= SWEEP;
`else
            state <= IDLE;
`endif
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (clear_go)
`ifdef DELAY_CLEAR_EN
                    next_state = SWEEP;
`else
                    next_state = IDLE;
`endif
                else if (delay_read_req)
                    next_state = RD_ADDR;
                else if (delay_write_req)
                    next_state = WR;
            end
            RD_ADDR: next_state = RD_DATA;
            RD_DATA: next_state = RELEASE;
            WR:      next_state = RELEASE;
            RELEASE: begin
                if (lat_is_read ? !delay_read_req : !delay_write_req)
                    next_state = IDLE;
            end
`ifdef DELAY_CLEAR_EN
            SWEEP: begin
                if (sweep_addr == aw'(depth - 1))
                    next_state = IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // RAM port control
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = {line, wptr[line]};
        ram_wdata = lat_arg;
        case (state)
            RD_ADDR: ram_addr = {line, rd_offset};
            WR:      ram_we   = handle_valid;
`ifdef DELAY_CLEAR_EN
            SWEEP: begin
                ram_we    = 1'b1;
                ram_addr  = sweep_addr;
                ram_wdata = '0;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: the sample RAM has no reset; clearing it is the optional sweep's job, not reset's.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    // Request latch, write pointers and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_handle        <= '0;
            lat_arg           <= '0;
            lat_is_read       <= 1'b0;
            delay_read_data   <= '0;
            delay_read_ready  <= 1'b0;
            delay_write_ready <= 1'b0;
            for (int i = 0; i < n_delays; i++)
                wptr[i] <= '0;
`ifdef DELAY_CLEAR_EN
            sweep_addr    <= '0;
            clear_pending <= 1'b0;
`endif
        end else begin
            delay_read_ready  <= (state == RD_DATA);
            delay_write_ready <= (state == WR);

            if (accept) begin
                lat_handle  <= delay_req_handle;
                lat_arg     <= delay_req_arg;
                lat_is_read <= delay_read_req;
            end

            if (state == RD_DATA)
                delay_read_data <= handle_valid ? ram_q : '0;

            if (state == WR && handle_valid)
                wptr[line] <= wptr[line] + ow'(1);

`ifdef DELAY_CLEAR_EN
            // A clear seen mid-request is remembered until the FSM is back in IDLE.
            if (state == SWEEP)
                clear_pending <= 1'b0;
            else if (clear && state != IDLE)
                clear_pending <= 1'b1;
            else if (state == IDLE && clear_go)
                clear_pending <= 1'b0;

            if (state == SWEEP) begin
                sweep_addr <= (sweep_addr == aw'(depth - 1)) ? '0 : sweep_addr + aw'(1);
                for (int i = 0; i < n_delays; i++)
                    wptr[i] <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_delay_line_server.sv
// Directed self-checking bench for delay_line_server (default build, DELAY_CLEAR_EN undefined).
module tb_delay_line_server;

    localparam int data_width = 16;
    localparam int n_delays   = 8;
    localparam int buf_len    = 1024;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         delay_read_req;
    logic                         delay_write_req;
    logic signed [data_width-1:0] delay_req_handle;
    logic signed [data_width-1:0] delay_req_arg;
    logic signed [data_width-1:0] delay_read_data;
    logic                         delay_read_ready;
    logic                         delay_write_ready;

    int n_checks = 0;
    int n_pass   = 0;

    delay_line_server #(
        .data_width(data_width),
        .n_delays  (n_delays),
        .buf_len   (buf_len)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .delay_read_req   (delay_read_req),
        .delay_write_req  (delay_write_req),
        .delay_req_handle (delay_req_handle),
        .delay_req_arg    (delay_req_arg),
        .delay_read_data  (delay_read_data),
        .delay_read_ready (delay_read_ready),
        .delay_write_ready(delay_write_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Cycle numbers count the accept edge as cycle 0; the negedge after edge k lies in cycle k+1.
    task automatic do_write(input logic signed [15:0] h, input logic signed [15:0] v, output int lat);
        @(negedge clk);
        delay_req_handle = h;
        delay_req_arg    = v;
        delay_write_req  = 1'b1;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (delay_write_ready) begin
                lat = c;
                break;
            end
        end
        delay_write_req = 1'b0;
    endtask

    task automatic do_read(input logic signed [15:0] h, input logic signed [15:0] a,
                           output logic [15:0] data, output int lat);
        @(negedge clk);
        delay_req_handle = h;
        delay_req_arg    = a;
        delay_read_req   = 1'b1;
        lat  = -1;
        data = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (delay_read_ready) begin
                lat  = c;
                data = delay_read_data;
                break;
            end
        end
        delay_read_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        int          lat;
        int          pulses;
        logic signed [15:0] rd_args [3];
        logic [15:0]        rd_exp  [3];

        reset            = 1'b0;
        delay_read_req   = 1'b0;
        delay_write_req  = 1'b0;
        delay_req_handle = '0;
        delay_req_arg    = '0;
        repeat (3) @(negedge clk);
        check("reset_read_data", delay_read_data, 16'h0000);
        check("reset_read_ready", 16'(delay_read_ready), 16'h0000);
        check("reset_write_ready", 16'(delay_write_ready), 16'h0000);
        reset = 1'b1;

        // Basic write/read latency on handle 2
        do_write(16'sd2, 16'sh1234, lat);
        check("h2_wr_latency", 16'(lat), 16'd2);
        do_read(16'sd2, 16'sd0, rd, lat);
        check("h2_rd_latency", 16'(lat), 16'd3);
        check("h2_rd_data", rd, 16'h1234);

        // Five samples on handle 0, taps at several depths
        for (int i = 1; i <= 5; i++)
            do_write(16'sd0, 16'(i), lat);
        rd_args = '{16'sd0, 16'sd4, 16'sd2};
        rd_exp  = '{16'd5, 16'd1, 16'd3};
        for (int i = 0; i < 3; i++) begin
            do_read(16'sd0, rd_args[i], rd, lat);
            check($sformatf("h0_tap%0d", rd_args[i]), rd, rd_exp[i]);
        end

        // Pointer wrap and arg clamping on handle 1
        for (int i = 0; i < buf_len + 3; i++)
            do_write(16'sd1, 16'(i), lat);
        do_read(16'sd1, 16'sd0, rd, lat);
        check("h1_wrap_tap0", rd, 16'd1026);
        do_read(16'sd1, 16'sd1023, rd, lat);
        check("h1_wrap_tap1023", rd, 16'd3);
        do_read(16'sd1, 16'sd2000, rd, lat);
        check("h1_clamp_high", rd, 16'd3);
        do_read(16'sd1, -16'sd7, rd, lat);
        check("h1_clamp_neg", rd, 16'd1026);

        // Simultaneous read and write on handle 3: read wins, write waits for read release
        do_write(16'sd3, 16'sh0055, lat);
        @(negedge clk);
        delay_req_handle = 16'sd3;
        delay_req_arg    = 16'sd0;
        delay_read_req   = 1'b1;
        delay_write_req  = 1'b1;
        lat    = -1;
        pulses = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (delay_write_ready) pulses++;
            if (delay_read_ready) begin
                lat = c;
                rd  = delay_read_data;
                break;
            end
        end
        check("simul_rd_latency", 16'(lat), 16'd3);
        check("simul_rd_data", rd, 16'h0055);
        delay_req_arg = 16'sh0077;
        repeat (3) begin
            @(negedge clk);
            if (delay_write_ready) pulses++;
        end
        check("simul_wr_held", 16'(pulses), 16'd0);
        delay_read_req = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (delay_write_ready) begin
                lat = c;
                break;
            end
        end
        delay_write_req = 1'b0;
        check("simul_wr_after_release", 16'(lat), 16'd3);
        do_read(16'sd3, 16'sd0, rd, lat);
        check("simul_new_value", rd, 16'h0077);

        // Out-of-range handle 9 (low bits alias line 1)
        do_write(16'sd9, 16'sh0999, lat);
        check("h9_wr_latency", 16'(lat), 16'd2);
        do_read(16'sd9, 16'sd0, rd, lat);
        check("h9_rd_latency", 16'(lat), 16'd3);
        check("h9_rd_data", rd, 16'h0000);
        do_read(16'sd1, 16'sd0, rd, lat);
        check("h9_line1_untouched", rd, 16'd1026);
        do_read(16'sd1, 16'sd1023, rd, lat);
        check("h9_line1_ptr_same", rd, 16'd3);

        // Held write request is serviced exactly once
        do_write(16'sd4, 16'sh0101, lat);
        @(negedge clk);
        delay_req_handle = 16'sd4;
        delay_req_arg    = 16'sh0A0A;
        delay_write_req  = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (delay_write_ready) pulses++;
        end
        delay_write_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (delay_write_ready) pulses++;
        end
        check("held_wr_pulses", 16'(pulses), 16'd1);
        do_read(16'sd4, 16'sd0, rd, lat);
        check("held_wr_tap0", rd, 16'h0A0A);
        do_read(16'sd4, 16'sd1, rd, lat);
        check("held_wr_tap1", rd, 16'h0101);

        // Reset during the RD_ADDR cycle aborts the read and zeroes all pointers
        @(negedge clk);
        delay_req_handle = 16'sd2;
        delay_req_arg    = 16'sd0;
        delay_read_req   = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        @(negedge clk);
        if (delay_read_ready) pulses++;
        check("abort_read_data_reset", delay_read_data, 16'h0000);
        reset          = 1'b1;
        delay_read_req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (delay_read_ready || delay_write_ready) pulses++;
        end
        check("abort_no_ready", 16'(pulses), 16'd0);
        do_read(16'sd1, 16'sd0, rd, lat);
        check("post_reset_h1_ptr0", rd, 16'd1023);
        do_read(16'sd0, 16'sd1023, rd, lat);
        check("post_reset_h0_ptr0", rd, 16'd1);
        do_read(16'sd2, 16'sd1023, rd, lat);
        check("post_reset_h2_ptr0", rd, 16'h1234);
        do_read(16'sd3, 16'sd1023, rd, lat);
        check("post_reset_h3_ptr0", rd, 16'h0055);
        do_read(16'sd4, 16'sd1023, rd, lat);
        check("post_reset_h4_ptr0", rd, 16'h0101);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
